omsp_spm_cmd_seq: RTL and testbench
===================================

OMSP_SPM_CMD_SEQ -- requirements
Module: omsp_spm_cmd_seq

Interface
REQ-001 SHALL have ports, in this order:
- mclk  in  1  clock.
- puc_rst  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  one-cycle command strobe.
- cmd_op  in  2  command: 00 PROTECT, 01 UNPROTECT, 10 QUERY, 11 reserved.
- violation  in  1  combinational violation from the SPM controller.
- spm_select_valid  in  1  a selected SPM exists.
- requested_data  in  16  combinational read data from the SPM controller.
- key_word  in  16  key source data.
- key_valid  in  1  key source data valid.
- key_ready  out  1  sequencer accepts key_word.
- update_spm  out  1  SPM update request.
- enable_spm  out  1  1 = create SPM, 0 = destroy SPM.
- write_key  out  1  key word write strobe.
- key_in  out  16  key word to the SPM controller.
- data_request  out  3  read selector, 0 = none.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  completion status, valid with done.
- query_data  out  16  captured read word.
- query_idx  out  3  index of query_data.
- query_valid  out  1  query_data/query_idx valid.
REQ-002 Parameters: KEY_WORDS, default 8, number of 16-bit key words (128-bit key). TIMEOUT, default 255, maximum idle cycles in KEYLOAD.

Function
REQ-003 States: IDLE, UPDATE, KEYLOAD, QUERY, DONE; binary encoded and registered.
REQ-004 IDLE: on cmd_start=1 latch cmd_op and go to UPDATE (PROTECT/UNPROTECT), QUERY (QUERY) or DONE with error=1 (reserved).
REQ-005 cmd_start SHALL be ignored while busy=1; busy=1 in every state except IDLE.
REQ-006 UPDATE lasts exactly one cycle with update_spm=1 and enable_spm=1 for PROTECT, 0 for UNPROTECT.
REQ-007 violation SHALL be sampled in the UPDATE cycle. If 1, go to DONE with error=1. If 0, PROTECT goes to KEYLOAD and UNPROTECT goes to DONE with error=0.
REQ-008 KEYLOAD: key_ready=1; word accepted when key_valid&key_ready; in the same cycle write_key=1 and key_in=key_word.
- write_key=0 and key_in=0 in all other cycles.
REQ-009 Accepted words are counted 0..KEY_WORDS-1 by a word counter. After the KEY_WORDS-th accept, go to DONE with error=0; key_ready drops the next cycle.
REQ-010 KEYLOAD idle counter:
- clears on each accept;
- increments on cycles with key_valid=0;
- on reaching TIMEOUT, go to DONE with error=1, keeping words already written.
REQ-011 QUERY, first cycle: if spm_select_valid=0, go to DONE with error=1 and issue no data_request.
REQ-012 QUERY: for n=1..4, drive data_request=n for one cycle each, back to back, and register requested_data.
- Next cycle: query_valid=1, query_data=captured word, query_idx=n.
- After the n=4 capture, go to DONE; query_valid for n=4 is coincident with done.
REQ-013 DONE lasts one cycle with done=1; error holds the status. Then go to IDLE.
- error is held until the next accepted cmd_start.
- done=0 in all other states.
REQ-014 data_request=0 and update_spm=0 outside QUERY and UPDATE respectively; enable_spm=0 outside UPDATE.
REQ-015 Counters SHALL not wrap. The word counter saturates at KEY_WORDS-1 and the idle counter is 8 bits; TIMEOUT must be <=255.

Reset
REQ-016 puc_rst=1 SHALL force state IDLE and all counters to 0 asynchronously.
REQ-017 Reset values: busy, done, error, update_spm, enable_spm, write_key, key_ready, query_valid = 0; key_in, query_data = 16'h0; data_request, query_idx = 3'h0.
REQ-018 Reset mid-command aborts it with no done pulse. The first command after reset release behaves as if from cold reset.

Configuration
REQ-019 Macro SPM_KEY_LOAD_EN:
- Defined: KEYLOAD exists as above.
- Undefined: PROTECT goes from UPDATE directly to DONE with error=violation sample; key_ready and write_key are tied 0, key_in is tied 16'h0, and the KEYLOAD counters are not synthesised.

Verification
REQ-020 PROTECT, violation=0, key source supplying words 16'h1111..16'h8888 one per cycle -> one update_spm/enable_spm pulse, then 8 write_key pulses with key_in 1111..8888 in order, then done=1, error=0.
REQ-021 PROTECT with violation=1 in the UPDATE cycle -> done=1 and error=1 one cycle later; write_key never asserted.
REQ-022 UNPROTECT -> update_spm=1 with enable_spm=0 for one cycle, done=1, error=0 on the next cycle; cmd_start pulsed while busy has no effect.
REQ-023 QUERY with spm_select_valid=1 and requested_data=16'hA000+data_request -> data_request 1,2,3,4 on consecutive cycles; query_data A001..A004 with query_idx 1..4; done on the last.
REQ-024 PROTECT with key_valid stuck 0 -> done=1, error=1 exactly TIMEOUT cycles after KEYLOAD entry. puc_rst pulsed during KEYLOAD -> all outputs at reset values, no done.

Source files
------------

// File: rtl/omsp_spm_cmd_seq.sv
// omsp_spm_cmd_seq: sequences SPM PROTECT/UNPROTECT/QUERY commands against the SPM controller.
// Key loading after PROTECT is built only when SPM_KEY_LOAD_EN is defined.
module omsp_spm_cmd_seq #(
    parameter int KEY_WORDS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    input  logic        violation,
    input  logic        spm_select_valid,
    input  logic [15:0] requested_data,
    input  logic [15:0] key_word,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        update_spm,
    output logic        enable_spm,
    output logic        write_key,
    output logic [15:0] key_in,
    output logic [2:0]  data_request,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] query_data,
    output logic [2:0]  query_idx,
    output logic        query_valid
);
    typedef enum logic [2:0] {IDLE, UPDATE, KEYLOAD, QUERY, DONE} state_t;
    localparam logic [1:0] OP_PROT = 2'd0, OP_QUERY = 2'd2, OP_RSVD = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        error_q, error_d;
    logic [1:0]  qn_q, qn_d;
    logic [15:0] query_data_q, query_data_d;
    logic [2:0]  query_idx_q, query_idx_d;
    logic        query_valid_q, query_valid_d;
    logic        key_accept;

`ifdef SPM_KEY_LOAD_EN
    localparam int WW = KEY_WORDS > 1 ? $clog2(KEY_WORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(KEY_WORDS - 1);
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;
    assign key_ready = state_q == KEYLOAD;
    always_comb begin
        word_cnt_d = '0;
        idle_cnt_d = '0;
        if (state_q == KEYLOAD) begin
            word_cnt_d = (key_accept && word_cnt_q != LAST_WORD) ? word_cnt_q + 1'b1 : word_cnt_q;
            idle_cnt_d = key_accept ? 8'd0 : idle_cnt_q + 8'd1;
        end
    end
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign key_ready = 1'b0;
`endif

    assign key_accept = key_ready & key_valid;
    assign write_key  = key_accept;
    assign key_in     = key_accept ? key_word : 16'h0;
    assign error       = error_q;
    assign query_data  = query_data_q;
    assign query_idx   = query_idx_q;
    assign query_valid = query_valid_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        error_d       = error_q;
        qn_d          = 2'd0;
        query_data_d  = query_data_q;
        query_idx_d   = query_idx_q;
        query_valid_d = 1'b0;
        busy          = state_q != IDLE;
        done          = state_q == DONE;
        update_spm    = state_q == UPDATE;
        enable_spm    = state_q == UPDATE && op_q == OP_PROT;
        data_request  = 3'd0;
        case (state_q)
            IDLE: if (cmd_start) begin
                op_d    = cmd_op;
                error_d = cmd_op == OP_RSVD;
                state_d = cmd_op == OP_RSVD ? DONE : cmd_op == OP_QUERY ? QUERY : UPDATE;
            end
            UPDATE: begin
                error_d = violation;
`ifdef SPM_KEY_LOAD_EN
                state_d = (op_q == OP_PROT && !violation) ? KEYLOAD : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef SPM_KEY_LOAD_EN
            KEYLOAD: begin
                if (key_accept && word_cnt_q == LAST_WORD) begin
                    state_d = DONE;
                    error_d = 1'b0;
                end else if (!key_valid && idle_cnt_q == IDLE_LAST) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
`endif
            QUERY: begin
                if (qn_q == 2'd0 && !spm_select_valid) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end else begin
                    // Selector n = qn_q + 1; its word is presented one cycle later.
                    data_request  = {1'b0, qn_q} + 3'd1;
                    query_data_d  = requested_data;
                    query_idx_d   = data_request;
                    query_valid_d = 1'b1;
                    qn_d          = qn_q + 2'd1;
                    if (qn_q == 2'd3) begin
                        state_d = DONE;
                        error_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q       <= IDLE;
            op_q          <= 2'd0;
            error_q       <= 1'b0;
            qn_q          <= 2'd0;
            query_data_q  <= 16'h0;
            query_idx_q   <= 3'd0;
            query_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            error_q       <= error_d;
            qn_q          <= qn_d;
            query_data_q  <= query_data_d;
            query_idx_q   <= query_idx_d;
            query_valid_q <= query_valid_d;
        end
    end
endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// tb_omsp_spm_cmd_seq: randomized command stream checked cycle by cycle against a command-level model.
module tb_omsp_spm_cmd_seq;
    localparam int KW = 8;
    localparam int TO = 12;
`ifdef SPM_KEY_LOAD_EN
    localparam bit KL = 1'b1;
`else
    localparam bit KL = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        puc_rst, cmd_start, violation, spm_select_valid, key_valid;
    logic [1:0]  cmd_op;
    logic [15:0] requested_data, key_word, rd_base;
    logic        key_ready, update_spm, enable_spm, write_key, busy, done, error, query_valid;
    logic [15:0] key_in, query_data;
    logic [2:0]  data_request, query_idx;

    int  n_chk = 0;
    int  n_fail = 0;
    logic exp_err = 1'b0;

    omsp_spm_cmd_seq #(.KEY_WORDS(KW), .TIMEOUT(TO)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .cmd_start(cmd_start), .cmd_op(cmd_op),
        .violation(violation), .spm_select_valid(spm_select_valid),
        .requested_data(requested_data), .key_word(key_word), .key_valid(key_valid),
        .key_ready(key_ready), .update_spm(update_spm), .enable_spm(enable_spm),
        .write_key(write_key), .key_in(key_in), .data_request(data_request),
        .busy(busy), .done(done), .error(error), .query_data(query_data),
        .query_idx(query_idx), .query_valid(query_valid)
    );

    always #5 mclk = ~mclk;
    assign requested_data = rd_base + 16'(data_request);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic noise();
        cmd_start = 1'($urandom);
        cmd_op    = 2'($urandom);
    endtask

    task automatic expect_out(input string t, input logic b, input logic u, input logic e,
                              input logic kr, input logic wk, input logic [15:0] ki,
                              input logic [2:0] dr, input logic d, input logic qv,
                              input logic [2:0] qi, input logic [15:0] qd);
        chk({t, ".busy"}, 32'(busy), 32'(b));
        chk({t, ".update_spm"}, 32'(update_spm), 32'(u));
        chk({t, ".enable_spm"}, 32'(enable_spm), 32'(e));
        chk({t, ".key_ready"}, 32'(key_ready), 32'(kr));
        chk({t, ".write_key"}, 32'(write_key), 32'(wk));
        chk({t, ".key_in"}, 32'(key_in), 32'(ki));
        chk({t, ".data_request"}, 32'(data_request), 32'(dr));
        chk({t, ".done"}, 32'(done), 32'(d));
        chk({t, ".error"}, 32'(error), 32'(exp_err));
        chk({t, ".query_valid"}, 32'(query_valid), 32'(qv));
        if (qv) begin
            chk({t, ".query_idx"}, 32'(query_idx), 32'(qi));
            chk({t, ".query_data"}, 32'(query_data), 32'(qd));
        end
    endtask

    task automatic idle_step(input string t);
        cmd_start = 1'b0;
        key_valid = 1'($urandom);
        #1 expect_out(t, 0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
        cyc();
    endtask

    task automatic done_step(input string t, input logic qv, input logic [15:0] qd);
        noise();
        key_valid = 1'($urandom);
        #1 expect_out(t, 1, 0, 0, 0, 0, 16'h0, 3'd0, 1, qv, 3'd4, qd);
        cyc();
    endtask

    // kmode: 0 random key source, 1 words 1111..8888 back to back, 2 key_valid stuck low
    task automatic do_cmd(input logic [1:0] op, input int viol, input int kmode, input int sel);
        logic v, s, kv;
        logic [15:0] w;
        int acc, idl, guard;
        cmd_start = 1'b1;
        cmd_op    = op;
        key_valid = 1'b0;
        #1 expect_out("accept", 0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
        cyc();
        exp_err = 1'b0;
        if (op == 2'd3) begin
            exp_err = 1'b1;
            done_step("rsvd_done", 0, 16'h0);
        end else if (op == 2'd2) begin
            s = sel < 0 ? ($urandom % 5 != 0) : 1'(sel);
            spm_select_valid = s;
            noise();
            if (!s) begin
                #1 expect_out("q_nosel", 1, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
                cyc();
                exp_err = 1'b1;
                done_step("q_nosel_done", 0, 16'h0);
            end else begin
                #1 expect_out("q_req1", 1, 0, 0, 0, 0, 16'h0, 3'd1, 0, 0, 3'd0, 16'h0);
                cyc();
                for (int n = 2; n <= 4; n++) begin
                    spm_select_valid = 1'($urandom);
                    noise();
                    #1 expect_out("q_req", 1, 0, 0, 0, 0, 16'h0, 3'(n), 0, 1, 3'(n - 1),
                                  rd_base + 16'(n - 1));
                    cyc();
                end
                done_step("q_done", 1, rd_base + 16'd4);
            end
        end else begin
            v = viol < 0 ? ($urandom % 3 == 0) : 1'(viol);
            violation = v;
            noise();
            #1 expect_out("update", 1, 1, op == 2'd0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
            cyc();
            violation = 1'($urandom);
            if (op == 2'd0 && !v && KL) begin
                acc = 0;
                idl = 0;
                guard = 0;
                while (acc < KW && idl < TO && guard < 500) begin
                    kv = kmode == 1 ? 1'b1 : kmode == 2 ? 1'b0 : ($urandom % 4 != 0);
                    w  = kmode == 1 ? 16'(16'h1111 * (acc + 1)) : 16'($urandom);
                    key_valid = kv;
                    key_word  = w;
                    noise();
                    #1 expect_out("keyload", 1, 0, 0, 1, kv, kv ? w : 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
                    cyc();
                    if (kv) begin
                        acc++;
                        idl = 0;
                    end else idl++;
                    guard++;
                end
                chk("keyload_bound", 32'(guard < 500), 32'd1);
                exp_err = acc < KW;
            end else exp_err = v;
            done_step("upd_done", 0, 16'h0);
        end
        idle_step("after_done");
    endtask

    task automatic reset_mid(input logic [1:0] op, input int steps);
        cmd_start = 1'b1;
        cmd_op    = op;
        violation = 1'b0;
        spm_select_valid = 1'b1;
        key_valid = 1'b1;
        cyc();
        for (int i = 0; i < steps; i++) begin
            noise();
            cyc();
        end
        #2 puc_rst = 1'b1;
        exp_err = 1'b0;
        #1 expect_out("rst_mid", 0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
        chk("rst_mid.query_idx", 32'(query_idx), 32'd0);
        chk("rst_mid.query_data", 32'(query_data), 32'd0);
        cyc();
        puc_rst = 1'b0;
        idle_step("rst_post1");
        idle_step("rst_post2");
    endtask

    initial begin
        puc_rst = 1'b1;
        cmd_start = 1'b0;
        cmd_op = 2'd0;
        violation = 1'b0;
        spm_select_valid = 1'b0;
        key_valid = 1'b0;
        key_word = 16'h0;
        rd_base = 16'hA000;
        @(negedge mclk);
        #1 expect_out("reset", 0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 3'd0, 16'h0);
        chk("reset.query_idx", 32'(query_idx), 32'd0);
        chk("reset.query_data", 32'(query_data), 32'd0);
        cyc();
        puc_rst = 1'b0;
        idle_step("idle0");
        do_cmd(2'd0, 0, 1, 1);
        do_cmd(2'd0, 1, 0, 1);
        do_cmd(2'd1, 0, 0, 1);
        do_cmd(2'd2, 0, 0, 1);
        do_cmd(2'd2, 0, 0, 0);
        do_cmd(2'd3, 0, 0, 1);
        do_cmd(2'd0, 0, 2, 1);
        reset_mid(2'd2, 1);
        if (KL) reset_mid(2'd0, 3);
        do_cmd(2'd1, 1, 0, 1);
        for (int i = 0; i < 40; i++) begin
            rd_base = 16'($urandom);
            do_cmd(2'($urandom), -1, ($urandom % 4 == 0) ? 2 : 0, -1);
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
